demux_stream_buf: RTL

//  Parametrised 1:NUM_CH registered stream demultiplexer, successor to demux14.

---
 rtl/demux_stream_buf.sv | 84 ++++++++
 1 files changed

// File: rtl/demux_stream_buf.sv
// 1:NUM_CH registered stream demultiplexer with a one-entry buffer and a
// valid/ready handshake per channel, plus unicast/broadcast routing.
module demux_stream_buf #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic                       in_bcast,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic                       sel_err,
    output logic [NUM_CH*CNT_W-1:0]    xfer_cnt
);

    // Extra bit so NUM_CH == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_CH_SEL = (SEL_W+1)'(NUM_CH);

    logic [NUM_CH-1:0]             full_q, full_d;
    logic [NUM_CH-1:0]             drain, space, load;
    logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                          sel_err_q, sel_err_d;
    logic                          sel_ok, sel_space, accept;

    // Handshake and routing decode
    always_comb begin
        drain     = full_q & out_ready;
        space     = ~full_q | out_ready;
        sel_ok    = ({1'b0, in_sel} < NUM_CH_SEL);
        sel_space = 1'b0;
        load      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) sel_space = space[k];
        end
        if (rst)           in_ready = 1'b0;
        else if (in_bcast) in_ready = &space;
        else if (!sel_ok)  in_ready = 1'b1;
        else               in_ready = sel_space;
        accept = in_valid & in_ready;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            load[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
        end
    end

    // Buffer, counter and error next state
    always_comb begin
        full_d    = load | (full_q & ~drain);
        data_d    = data_q;
        cnt_d     = cnt_q;
        sel_err_d = sel_err_q | (accept & ~in_bcast & ~sel_ok);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (load[k])  data_d[k] = in_data;
            if (drain[k]) cnt_d[k]  = cnt_q[k] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign xfer_cnt  = cnt_q;
    assign sel_err   = sel_err_q;

endmodule
